// File: rtl/bus_interconnect.sv
// Single-master, two-slave address-decoding interconnect with a per-transaction
// timeout, an unmapped-address error response and a sticky error-address log.
module bus_interconnect #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        I_BUS_EN,
    input  logic        I_BUS_WE,
    input  logic [1:0]  I_BUS_SIZE,
    input  logic [15:0] I_BUS_ADDR,
    input  logic [31:0] I_BUS_WRITE_DATA,
    output logic        O_BUS_RDY,
    output logic [31:0] O_BUS_READ_DATA,
    output logic        O_BUS_ERR,
    output logic [15:0] O_ERR_ADDR,
    input  logic        I_ERR_CLR,
    output logic [15:0] O_S_ADDR,
    output logic [1:0]  O_S_SIZE,
    output logic [31:0] O_S_WDATA,
    output logic        O_S0_EN,
    output logic        O_S0_WE,
    output logic        O_S1_EN,
    output logic        O_S1_WE,
    input  logic        I_S0_RDY,
    input  logic        I_S1_RDY,
    input  logic [31:0] I_S0_RDATA,
    input  logic [31:0] I_S1_RDATA
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The count runs 0..TIMEOUT_CYCLES-1 while the strobe is held.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        armed_q, armed_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        sel_q, sel_d;
    logic        we_q, we_d;
    logic [15:0] s_addr_q, s_addr_d;
    logic [1:0]  s_size_q, s_size_d;
    logic [31:0] s_wdata_q, s_wdata_d;
    logic        s0_en_q, s0_en_d, s0_we_q, s0_we_d;
    logic        s1_en_q, s1_en_d, s1_we_q, s1_we_d;
    logic        rdy_q, rdy_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] err_addr_q, err_addr_d;

    logic        req_s;
    logic        unmapped_s;
    logic        slave_rdy_s;
    logic        set_err_s;

    assign req_s       = I_BUS_EN | I_BUS_WE;
    assign unmapped_s  = (I_BUS_ADDR[15:14] == 2'b11);
    assign slave_rdy_s = sel_q ? I_S1_RDY : I_S0_RDY;

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_d    = state_q;
        armed_d    = req_s ? armed_q : 1'b1;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        we_d       = we_q;
        s_addr_d   = s_addr_q;
        s_size_d   = s_size_q;
        s_wdata_d  = s_wdata_q;
        s0_en_d    = s0_en_q;
        s0_we_d    = s0_we_q;
        s1_en_d    = s1_en_q;
        s1_we_d    = s1_we_q;
        rdy_d      = 1'b0;
        rdata_d    = rdata_q;
        err_addr_d = err_addr_q;
        set_err_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (armed_q && req_s) begin
                    armed_d   = 1'b0;
                    cnt_d     = 8'd0;
                    sel_d     = I_BUS_ADDR[15];
                    we_d      = I_BUS_WE;
                    s_addr_d  = I_BUS_ADDR;
                    s_size_d  = I_BUS_SIZE;
                    s_wdata_d = I_BUS_WRITE_DATA;
                    if (unmapped_s) begin
                        state_d    = ST_DONE;
                        rdy_d      = 1'b1;
                        rdata_d    = ERR_DATA;
                        set_err_s  = 1'b1;
                        err_addr_d = I_BUS_ADDR;
                    end else begin
                        state_d = ST_WAIT;
                        s0_en_d = ~I_BUS_ADDR[15] & ~I_BUS_WE;
                        s0_we_d = ~I_BUS_ADDR[15] &  I_BUS_WE;
                        s1_en_d =  I_BUS_ADDR[15] & ~I_BUS_WE;
                        s1_we_d =  I_BUS_ADDR[15] &  I_BUS_WE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (slave_rdy_s) begin
                    state_d = ST_DONE;
                    rdy_d   = 1'b1;
                    rdata_d = we_q ? 32'h0000_0000 : (sel_q ? I_S1_RDATA : I_S0_RDATA);
                    s0_en_d = 1'b0;
                    s0_we_d = 1'b0;
                    s1_en_d = 1'b0;
                    s1_we_d = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d    = ST_DONE;
                    rdy_d      = 1'b1;
                    rdata_d    = ERR_DATA;
                    set_err_s  = 1'b1;
                    err_addr_d = s_addr_q;
                    s0_en_d    = 1'b0;
                    s0_we_d    = 1'b0;
                    s1_en_d    = 1'b0;
                    s1_we_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                s0_en_d = 1'b0;
                s0_we_d = 1'b0;
                s1_en_d = 1'b0;
                s1_we_d = 1'b0;
            end
        endcase

        // A new error outranks a simultaneous clear.
        if (set_err_s) begin
            err_d = 1'b1;
        end else if (I_ERR_CLR) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            armed_q    <= 1'b1;
            cnt_q      <= 8'd0;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            s_addr_q   <= 16'h0000;
            s_size_q   <= 2'b00;
            s_wdata_q  <= 32'h0000_0000;
            s0_en_q    <= 1'b0;
            s0_we_q    <= 1'b0;
            s1_en_q    <= 1'b0;
            s1_we_q    <= 1'b0;
            rdy_q      <= 1'b0;
            rdata_q    <= 32'h0000_0000;
            err_q      <= 1'b0;
            err_addr_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            s_addr_q   <= s_addr_d;
            s_size_q   <= s_size_d;
            s_wdata_q  <= s_wdata_d;
            s0_en_q    <= s0_en_d;
            s0_we_q    <= s0_we_d;
            s1_en_q    <= s1_en_d;
            s1_we_q    <= s1_we_d;
            rdy_q      <= rdy_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign O_BUS_RDY       = rdy_q;
    assign O_BUS_READ_DATA = rdata_q;
    assign O_BUS_ERR       = err_q;
    assign O_ERR_ADDR      = err_addr_q;
    assign O_S_ADDR        = s_addr_q;
    assign O_S_SIZE        = s_size_q;
    assign O_S_WDATA       = s_wdata_q;
    assign O_S0_EN         = s0_en_q;
    assign O_S0_WE         = s0_we_q;
    assign O_S1_EN         = s1_en_q;
    assign O_S1_WE         = s1_we_q;

endmodule

// File: tb/tb_bus_interconnect.sv
// Cycle-table bench for bus_interconnect: each record drives one cycle of inputs
// and lists the registered outputs expected just after the following rising edge.
module tb_bus_interconnect;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        I_BUS_EN, I_BUS_WE, I_ERR_CLR, I_S0_RDY, I_S1_RDY;
    logic [1:0]  I_BUS_SIZE;
    logic [15:0] I_BUS_ADDR;
    logic [31:0] I_BUS_WRITE_DATA, I_S0_RDATA, I_S1_RDATA;
    logic        O_BUS_RDY, O_BUS_ERR, O_S0_EN, O_S0_WE, O_S1_EN, O_S1_WE;
    logic [31:0] O_BUS_READ_DATA, O_S_WDATA;
    logic [15:0] O_ERR_ADDR, O_S_ADDR;
    logic [1:0]  O_S_SIZE;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    bus_interconnect #(.TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .I_BUS_EN(I_BUS_EN), .I_BUS_WE(I_BUS_WE), .I_BUS_SIZE(I_BUS_SIZE),
        .I_BUS_ADDR(I_BUS_ADDR), .I_BUS_WRITE_DATA(I_BUS_WRITE_DATA),
        .O_BUS_RDY(O_BUS_RDY), .O_BUS_READ_DATA(O_BUS_READ_DATA),
        .O_BUS_ERR(O_BUS_ERR), .O_ERR_ADDR(O_ERR_ADDR), .I_ERR_CLR(I_ERR_CLR),
        .O_S_ADDR(O_S_ADDR), .O_S_SIZE(O_S_SIZE), .O_S_WDATA(O_S_WDATA),
        .O_S0_EN(O_S0_EN), .O_S0_WE(O_S0_WE), .O_S1_EN(O_S1_EN), .O_S1_WE(O_S1_WE),
        .I_S0_RDY(I_S0_RDY), .I_S1_RDY(I_S1_RDY),
        .I_S0_RDATA(I_S0_RDATA), .I_S1_RDATA(I_S1_RDATA)
    );

    // ctl = {rst_n, en, we, clr, s0_rdy, s1_rdy}; strb = {s1_we, s1_en, s0_we, s0_en}
    typedef struct {
        string       name;
        logic [5:0]  ctl;
        logic [1:0]  size;
        logic [15:0] addr;
        logic [31:0] wdata, rd0, rd1;
        logic        x_rdy;
        logic [31:0] x_rdata;
        logic        x_err;
        logic [15:0] x_eaddr;
        logic [3:0]  x_strb;
        logic [15:0] x_saddr;
        logic [1:0]  x_ssize;
        logic [31:0] x_swdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, logic [5:0] ctl, logic [1:0] sz, logic [15:0] a,
                                logic [31:0] wd, logic [31:0] d0, logic [31:0] d1,
                                logic xr, logic [31:0] xd, logic xe, logic [15:0] xea,
                                logic [3:0] xs, logic [15:0] xsa, logic [1:0] xsz,
                                logic [31:0] xsw);
        vec_t v;
        v.name = nm; v.ctl = ctl; v.size = sz; v.addr = a; v.wdata = wd;
        v.rd0 = d0; v.rd1 = d1; v.x_rdy = xr; v.x_rdata = xd; v.x_err = xe;
        v.x_eaddr = xea; v.x_strb = xs; v.x_saddr = xsa; v.x_ssize = xsz;
        v.x_swdata = xsw;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        logic [3:0] strb;
        {rst_n, I_BUS_EN, I_BUS_WE, I_ERR_CLR, I_S0_RDY, I_S1_RDY} = v.ctl;
        I_BUS_SIZE       = v.size;
        I_BUS_ADDR       = v.addr;
        I_BUS_WRITE_DATA = v.wdata;
        I_S0_RDATA       = v.rd0;
        I_S1_RDATA       = v.rd1;
        @(posedge clk_i);
        #1;
        strb = {O_S1_WE, O_S1_EN, O_S0_WE, O_S0_EN};
        n_vec++;
        if (O_BUS_RDY !== v.x_rdy || (v.x_rdy && O_BUS_READ_DATA !== v.x_rdata) ||
            O_BUS_ERR !== v.x_err || O_ERR_ADDR !== v.x_eaddr || strb !== v.x_strb ||
            O_S_ADDR !== v.x_saddr || O_S_SIZE !== v.x_ssize || O_S_WDATA !== v.x_swdata) begin
            n_fail++;
            $display("FAIL %s: got/exp rdy=%b/%b rdata=%h/%h err=%b/%b eaddr=%h/%h strb=%b/%b saddr=%h/%h size=%b/%b wdata=%h/%h",
                     v.name, O_BUS_RDY, v.x_rdy, O_BUS_READ_DATA, v.x_rdata, O_BUS_ERR, v.x_err,
                     O_ERR_ADDR, v.x_eaddr, strb, v.x_strb, O_S_ADDR, v.x_saddr,
                     O_S_SIZE, v.x_ssize, O_S_WDATA, v.x_swdata);
        end
    endtask

    initial begin
        // Reset, slave-0 write, slave-1 byte read, unmapped read, hold-after-RDY.
        tbl.push_back(mk("reset",      6'b000000, 2'd0, 16'h0000, 32'h0, 32'h0, 32'h0,
                         1'b0, 32'h0, 1'b0, 16'h0000, 4'b0000, 16'h0000, 2'd0, 32'h0));
        tbl.push_back(mk("idle",       6'b100000, 2'd0, 16'h0000, 32'h0, 32'h0, 32'h0,
                         1'b0, 32'h0, 1'b0, 16'h0000, 4'b0000, 16'h0000, 2'd0, 32'h0));
        tbl.push_back(mk("wr_acc",     6'b101000, 2'd2, 16'h0010, 32'h12345678, 32'h0, 32'h0,
                         1'b0, 32'h0, 1'b0, 16'h0000, 4'b0010, 16'h0010, 2'd2, 32'h12345678));
        tbl.push_back(mk("wr_wait",    6'b100000, 2'd0, 16'h0000, 32'h0, 32'h0, 32'h0,
                         1'b0, 32'h0, 1'b0, 16'h0000, 4'b0010, 16'h0010, 2'd2, 32'h12345678));
        tbl.push_back(mk("wr_rdy",     6'b100010, 2'd0, 16'h0000, 32'h0, 32'hFFFFFFFF, 32'h0,
                         1'b1, 32'h0, 1'b0, 16'h0000, 4'b0000, 16'h0010, 2'd2, 32'h12345678));
        tbl.push_back(mk("wr_done",    6'b100000, 2'd0, 16'h0000, 32'h0, 32'h0, 32'h0,
                         1'b0, 32'h0, 1'b0, 16'h0000, 4'b0000, 16'h0010, 2'd2, 32'h12345678));
        tbl.push_back(mk("rd1_acc",    6'b110000, 2'd0, 16'h8004, 32'h0, 32'h0, 32'h0,
                         1'b0, 32'h0, 1'b0, 16'h0000, 4'b0100, 16'h8004, 2'd0, 32'h0));
        tbl.push_back(mk("rd1_rdy",    6'b100001, 2'd0, 16'h0000, 32'h0, 32'h11111111, 32'hA5A5A5A5,
                         1'b1, 32'hA5A5A5A5, 1'b0, 16'h0000, 4'b0000, 16'h8004, 2'd0, 32'h0));
        tbl.push_back(mk("rd1_done",   6'b100000, 2'd0, 16'h0000, 32'h0, 32'h0, 32'h0,
                         1'b0, 32'h0, 1'b0, 16'h0000, 4'b0000, 16'h8004, 2'd0, 32'h0));
        tbl.push_back(mk("unmap",      6'b110000, 2'd2, 16'hC000, 32'h0, 32'h0, 32'h0,
                         1'b1, 32'hDEADBEEF, 1'b1, 16'hC000, 4'b0000, 16'hC000, 2'd2, 32'h0));
        tbl.push_back(mk("unmap_done", 6'b100000, 2'd0, 16'h0000, 32'h0, 32'h0, 32'h0,
                         1'b0, 32'h0, 1'b1, 16'hC000, 4'b0000, 16'hC000, 2'd2, 32'h0));
        tbl.push_back(mk("err_clr",    6'b100100, 2'd0, 16'h0000, 32'h0, 32'h0, 32'h0,
                         1'b0, 32'h0, 1'b0, 16'hC000, 4'b0000, 16'hC000, 2'd2, 32'h0));
        tbl.push_back(mk("hold_acc",   6'b110000, 2'd2, 16'h0100, 32'h0, 32'h0, 32'h0,
                         1'b0, 32'h0, 1'b0, 16'hC000, 4'b0001, 16'h0100, 2'd2, 32'h0));
        tbl.push_back(mk("stray_s1",   6'b110001, 2'd2, 16'h0100, 32'h0, 32'h0, 32'h77777777,
                         1'b0, 32'h0, 1'b0, 16'hC000, 4'b0001, 16'h0100, 2'd2, 32'h0));
        tbl.push_back(mk("hold_rdy",   6'b110010, 2'd2, 16'h0100, 32'h0, 32'hCAFEF00D, 32'h77777777,
                         1'b1, 32'hCAFEF00D, 1'b0, 16'hC000, 4'b0000, 16'h0100, 2'd2, 32'h0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk("hold_no_reacc", 6'b110000, 2'd2, 16'h0100, 32'h0, 32'h0, 32'h0,
                             1'b0, 32'h0, 1'b0, 16'hC000, 4'b0000, 16'h0100, 2'd2, 32'h0));
        tbl.push_back(mk("drop",       6'b100000, 2'd0, 16'h0000, 32'h0, 32'h0, 32'h0,
                         1'b0, 32'h0, 1'b0, 16'hC000, 4'b0000, 16'h0100, 2'd2, 32'h0));
        tbl.push_back(mk("reacc",      6'b110000, 2'd1, 16'h4008, 32'h0, 32'h0, 32'h0,
                         1'b0, 32'h0, 1'b0, 16'hC000, 4'b0001, 16'h4008, 2'd1, 32'h0));
        tbl.push_back(mk("reacc_rdy",  6'b100010, 2'd0, 16'h0000, 32'h0, 32'h0BADCAFE, 32'h0,
                         1'b1, 32'h0BADCAFE, 1'b0, 16'hC000, 4'b0000, 16'h4008, 2'd1, 32'h0));
        tbl.push_back(mk("reacc_done", 6'b100000, 2'd0, 16'h0000, 32'h0, 32'h0, 32'h0,
                         1'b0, 32'h0, 1'b0, 16'hC000, 4'b0000, 16'h4008, 2'd1, 32'h0));
        tbl.push_back(mk("wr_s1",      6'b111000, 2'd2, 16'h8010, 32'h55AA55AA, 32'h0, 32'h0,
                         1'b0, 32'h0, 1'b0, 16'hC000, 4'b1000, 16'h8010, 2'd2, 32'h55AA55AA));
        tbl.push_back(mk("wr_s1_rdy",  6'b100001, 2'd0, 16'h0000, 32'h0, 32'h0, 32'hFFFFFFFF,
                         1'b1, 32'h0, 1'b0, 16'hC000, 4'b0000, 16'h8010, 2'd2, 32'h55AA55AA));
        tbl.push_back(mk("rdy_in_idle", 6'b100011, 2'd0, 16'h0000, 32'h0, 32'h0, 32'h0,
                         1'b0, 32'h0, 1'b0, 16'hC000, 4'b0000, 16'h8010, 2'd2, 32'h55AA55AA));

        foreach (tbl[i]) apply(tbl[i]);

        // Timeout: strobe held exactly 8 cycles, then an error response.
        apply(mk("to_acc",   6'b110000, 2'd2, 16'h0200, 32'h0, 32'h0, 32'h0,
                 1'b0, 32'h0, 1'b0, 16'hC000, 4'b0001, 16'h0200, 2'd2, 32'h0));
        for (int i = 1; i < 8; i++)
            apply(mk("to_wait", 6'b100001, 2'd0, 16'h0000, 32'h0, 32'h0, 32'h0,
                     1'b0, 32'h0, 1'b0, 16'hC000, 4'b0001, 16'h0200, 2'd2, 32'h0));
        apply(mk("to_err",   6'b100000, 2'd0, 16'h0000, 32'h0, 32'h0, 32'h0,
                 1'b1, 32'hDEADBEEF, 1'b1, 16'h0200, 4'b0000, 16'h0200, 2'd2, 32'h0));
        apply(mk("to_done",  6'b100000, 2'd0, 16'h0000, 32'h0, 32'h0, 32'h0,
                 1'b0, 32'h0, 1'b1, 16'h0200, 4'b0000, 16'h0200, 2'd2, 32'h0));
        apply(mk("to_clr",   6'b100100, 2'd0, 16'h0000, 32'h0, 32'h0, 32'h0,
                 1'b0, 32'h0, 1'b0, 16'h0200, 4'b0000, 16'h0200, 2'd2, 32'h0));
        apply(mk("clr_vs_set", 6'b110100, 2'd2, 16'hFFFC, 32'h0, 32'h0, 32'h0,
                 1'b1, 32'hDEADBEEF, 1'b1, 16'hFFFC, 4'b0000, 16'hFFFC, 2'd2, 32'h0));
        apply(mk("set_wins", 6'b100000, 2'd0, 16'h0000, 32'h0, 32'h0, 32'h0,
                 1'b0, 32'h0, 1'b1, 16'hFFFC, 4'b0000, 16'hFFFC, 2'd2, 32'h0));

        // Reset while in WAIT, with the request held through reset.
        apply(mk("rst_acc",  6'b110000, 2'd2, 16'h0300, 32'h0, 32'h0, 32'h0,
                 1'b0, 32'h0, 1'b1, 16'hFFFC, 4'b0001, 16'h0300, 2'd2, 32'h0));
        apply(mk("rst_mid",  6'b010000, 2'd2, 16'h0300, 32'h0, 32'h0, 32'h0,
                 1'b0, 32'h0, 1'b0, 16'h0000, 4'b0000, 16'h0000, 2'd0, 32'h0));
        apply(mk("post_rst_acc", 6'b110000, 2'd2, 16'h0300, 32'h0, 32'h0, 32'h0,
                 1'b0, 32'h0, 1'b0, 16'h0000, 4'b0001, 16'h0300, 2'd2, 32'h0));
        apply(mk("post_rst_rdy", 6'b100010, 2'd0, 16'h0000, 32'h0, 32'h13579BDF, 32'h0,
                 1'b1, 32'h13579BDF, 1'b0, 16'h0000, 4'b0000, 16'h0300, 2'd2, 32'h0));
        apply(mk("post_rst_done", 6'b100000, 2'd0, 16'h0000, 32'h0, 32'h0, 32'h0,
                 1'b0, 32'h0, 1'b0, 16'h0000, 4'b0000, 16'h0300, 2'd2, 32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
